// File: rtl/csr_stage_if.sv
// Execute-to-CSR command bus and CSR-to-writeback result bus of the csr_stage.
// The master side is the pipeline (execute drives commands, writeback consumes
// results); the slave side is the CSR/trap unit itself.
interface csr_stage_if;
    logic [2:0]  input_csr_cmd;
    logic [31:0] input_op1_data;
    logic [31:0] input_imm_i;
    logic [2:0]  output_csr_cmd;
    logic [31:0] csr_rdata;
    logic [31:0] trap_vector;

    modport master (
        output input_csr_cmd,
        output input_op1_data,
        output input_imm_i,
        input  output_csr_cmd,
        input  csr_rdata,
        input  trap_vector
    );

    modport slave (
        input  input_csr_cmd,
        input  input_op1_data,
        input  input_imm_i,
        output output_csr_cmd,
        output csr_rdata,
        output trap_vector
    );
endinterface

// File: rtl/csr_stage.sv
// Machine-mode CSR file and trap unit sitting between execute and writeback.
// Registers one CSR command per cycle, updates the CSR file, returns the old
// CSR value and the redirect target, and owns the machine timer interrupt.
module csr_stage #(
    parameter int FMAX_MHz = 27
) (
    input  logic        clk,
    input  logic        rst_n,
    csr_stage_if.slave  bus,
    input  logic [63:0] reg_cycle,
    input  logic [63:0] reg_time,
    input  logic [63:0] reg_mtime,
    input  logic [63:0] reg_mtimecmp,
    input  logic        wb_branch_hazard,
    input  logic        input_interrupt_ready,
    input  logic [31:0] if_reg_pc,
    output logic        output_stall_flg_may_interrupt
);
    localparam logic [2:0] CMD_X = 3'd0;
    localparam logic [2:0] CMD_W = 3'd1;
    localparam logic [2:0] CMD_S = 3'd2;
    localparam logic [2:0] CMD_C = 3'd3;
    localparam logic [2:0] CMD_E = 3'd4;
    localparam logic [2:0] CMD_V = 3'd5;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_CYCLE    = 12'hC00;
    localparam logic [11:0] A_TIME     = 12'hC01;
    localparam logic [11:0] A_CYCLEH   = 12'hC80;
    localparam logic [11:0] A_TIMEH    = 12'hC81;
    localparam logic [11:0] A_FMAX     = 12'hFC0;

    // CSR state
    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic        r_mie_mtie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;

    // Writeback-facing result registers
    logic [2:0]  r_out_cmd;
    logic [31:0] r_rdata;
    logic [31:0] r_trap_vector;

    logic [11:0] w_addr;
    logic [2:0]  w_cmd;
    logic        w_mtip;
    logic        w_pending;
    logic        w_take_irq;
    logic [31:0] w_old;
    logic [31:0] w_wval;
    logic        w_unused_bits;

    assign w_addr        = bus.input_imm_i[11:0];
    assign w_unused_bits = ^bus.input_imm_i[31:12];
    // A redirect from writeback squashes whatever execute is presenting.
    assign w_cmd         = wb_branch_hazard ? CMD_X : bus.input_csr_cmd;
    assign w_mtip        = (reg_mtime >= reg_mtimecmp);
    assign w_pending     = r_mstatus_mie & r_mie_mtie & w_mtip;
    // Instructions win over the interrupt; it is retaken once the stage is idle.
    assign w_take_irq    = w_pending & input_interrupt_ready &
                           (bus.input_csr_cmd == CMD_X) & ~wb_branch_hazard;

    assign output_stall_flg_may_interrupt = w_pending & ~wb_branch_hazard;

    assign bus.output_csr_cmd = r_out_cmd;
    assign bus.csr_rdata      = r_rdata;
    assign bus.trap_vector    = r_trap_vector;

    // Read mux: current (pre-edge) value of the addressed CSR.
    always_comb begin
        w_old = '0;
        case (w_addr)
            A_MSTATUS:  w_old = {24'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
            A_MIE:      w_old = {24'b0, r_mie_mtie, 7'b0};
            A_MTVEC:    w_old = r_mtvec;
            A_MSCRATCH: w_old = r_mscratch;
            A_MEPC:     w_old = r_mepc;
            A_MCAUSE:   w_old = r_mcause;
            A_MIP:      w_old = {24'b0, w_mtip, 7'b0};
            A_CYCLE:    w_old = reg_cycle[31:0];
            A_CYCLEH:   w_old = reg_cycle[63:32];
            A_TIME:     w_old = reg_time[31:0];
            A_TIMEH:    w_old = reg_time[63:32];
            A_FMAX:     w_old = 32'(FMAX_MHz);
            default:    w_old = '0;
        endcase
    end

    // New value for W/S/C commands.
    always_comb begin
        w_wval = bus.input_op1_data;
        case (w_cmd)
            CMD_S:   w_wval = w_old | bus.input_op1_data;
            CMD_C:   w_wval = w_old & ~bus.input_op1_data;
            default: w_wval = bus.input_op1_data;
        endcase
    end

    // CSR file update, trap entry/return and registered writeback outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie_mtie     <= 1'b0;
            r_mtvec        <= '0;
            r_mscratch     <= '0;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_out_cmd      <= CMD_X;
            r_rdata        <= '0;
            r_trap_vector  <= '0;
        end else if (w_take_irq) begin
            r_mepc         <= if_reg_pc;
            r_mcause       <= 32'h8000_0007;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
            r_out_cmd      <= CMD_E;
            r_trap_vector  <= r_mtvec;
            r_rdata        <= '0;
        end else begin
            r_trap_vector <= r_mtvec;
            case (w_cmd)
                CMD_W, CMD_S, CMD_C: begin
                    r_out_cmd <= w_cmd;
                    r_rdata   <= w_old;
                    case (w_addr)
                        A_MSTATUS: begin
                            r_mstatus_mie  <= w_wval[3];
                            r_mstatus_mpie <= w_wval[7];
                        end
                        A_MIE:      r_mie_mtie <= w_wval[7];
                        A_MTVEC:    r_mtvec    <= w_wval;
                        A_MSCRATCH: r_mscratch <= w_wval;
                        A_MEPC:     r_mepc     <= w_wval;
                        A_MCAUSE:   r_mcause   <= w_wval;
                        default:    ;
                    endcase
                end
                CMD_E: begin
                    r_out_cmd      <= CMD_E;
                    r_rdata        <= w_old;
                    r_mepc         <= bus.input_op1_data;
                    r_mcause       <= 32'd11;
                    r_mstatus_mpie <= r_mstatus_mie;
                    r_mstatus_mie  <= 1'b0;
                end
                CMD_V: begin
                    r_out_cmd      <= CMD_V;
                    r_rdata        <= w_old;
                    r_mstatus_mie  <= r_mstatus_mpie;
                    r_mstatus_mpie <= 1'b1;
                    r_trap_vector  <= r_mepc;
                end
                default: begin
                    r_out_cmd <= CMD_X;
                    r_rdata   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_csr_stage.sv
// Directed bench for csr_stage: the driver pushes the expected writeback result
// of each command into a queue; a monitor pops and compares after each edge.
module tb_csr_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [63:0] reg_cycle = '0;
    logic [63:0] reg_time = '0;
    logic [63:0] reg_mtime = '0;
    logic [63:0] reg_mtimecmp = 64'd1;
    logic        wb_branch_hazard = 1'b0;
    logic        input_interrupt_ready = 1'b0;
    logic [31:0] if_reg_pc = '0;
    logic        stall;

    int n_tests = 0;
    int n_fail  = 0;

    csr_stage_if bus ();

    csr_stage #(.FMAX_MHz(27)) dut (
        .clk                            (clk),
        .rst_n                          (rst_n),
        .bus                            (bus),
        .reg_cycle                      (reg_cycle),
        .reg_time                       (reg_time),
        .reg_mtime                      (reg_mtime),
        .reg_mtimecmp                   (reg_mtimecmp),
        .wb_branch_hazard               (wb_branch_hazard),
        .input_interrupt_ready          (input_interrupt_ready),
        .if_reg_pc                      (if_reg_pc),
        .output_stall_flg_may_interrupt (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  cmd;
        logic [31:0] rd;
        logic [31:0] tv;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one command on the falling edge and queue its expected result.
    task automatic step(input string name, input logic [2:0] cmd, input logic [11:0] addr,
                        input logic [31:0] op1, input logic hz, input logic rdy,
                        input logic [31:0] pc, input logic [2:0] ecmd,
                        input logic [31:0] erd, input logic [31:0] etv);
        exp_t e;
        @(negedge clk);
        bus.input_csr_cmd     = cmd;
        bus.input_imm_i       = {20'b0, addr};
        bus.input_op1_data    = op1;
        wb_branch_hazard      = hz;
        input_interrupt_ready = rdy;
        if_reg_pc             = pc;
        e.name = name;
        e.cmd  = ecmd;
        e.rd   = erd;
        e.tv   = etv;
        sb.push_back(e);
    endtask

    task automatic chk_stall(input string name, input logic exp);
        #1;
        check(name, {31'b0, stall}, {31'b0, exp});
    endtask

    task automatic idle_inputs();
        bus.input_csr_cmd     = 3'd0;
        bus.input_imm_i       = '0;
        bus.input_op1_data    = '0;
        wb_branch_hazard      = 1'b0;
        input_interrupt_ready = 1'b0;
    endtask

    // Monitor: compare the registered outputs presented after each edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            check({cur.name, ".cmd"}, {29'b0, bus.output_csr_cmd}, {29'b0, cur.cmd});
            check({cur.name, ".rdata"}, bus.csr_rdata, cur.rd);
            check({cur.name, ".tvec"}, bus.trap_vector, cur.tv);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        #2 rst_n = 1'b0;
        #1;
        check("rst.cmd", {29'b0, bus.output_csr_cmd}, 32'd0);
        check("rst.rdata", bus.csr_rdata, 32'd0);
        check("rst.tvec", bus.trap_vector, 32'd0);
        check("rst.stall", {31'b0, stall}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // mtvec read-modify-write
        step("w_mtvec", 3'd1, 12'h305, 32'h100, 0, 0, 0, 3'd1, 32'h0,   32'h0);
        step("s_mtvec", 3'd2, 12'h305, 32'h3,   0, 0, 0, 3'd2, 32'h100, 32'h100);
        step("c_mtvec", 3'd3, 12'h305, 32'h1,   0, 0, 0, 3'd3, 32'h103, 32'h103);
        step("r_mtvec", 3'd2, 12'h305, 32'h0,   0, 0, 0, 3'd2, 32'h102, 32'h102);
        step("w_mtvec2",3'd1, 12'h305, 32'h200, 0, 0, 0, 3'd1, 32'h102, 32'h102);
        // ecall / mret
        step("set_mie", 3'd1, 12'h300, 32'h8,   0, 0, 0, 3'd1, 32'h0,   32'h200);
        step("ecall",   3'd4, 12'h000, 32'h80,  0, 0, 0, 3'd4, 32'h0,   32'h200);
        step("r_mstat", 3'd2, 12'h300, 32'h0,   0, 0, 0, 3'd2, 32'h80,  32'h200);
        step("r_mepc",  3'd2, 12'h341, 32'h0,   0, 0, 0, 3'd2, 32'h80,  32'h200);
        step("r_mcause",3'd2, 12'h342, 32'h0,   0, 0, 0, 3'd2, 32'd11,  32'h200);
        step("mret",    3'd5, 12'h000, 32'h0,   0, 0, 0, 3'd5, 32'h0,   32'h80);
        step("r_mstat2",3'd2, 12'h300, 32'h0,   0, 0, 0, 3'd2, 32'h88,  32'h200);
        // timer interrupt
        reg_mtime    = 64'd10;
        reg_mtimecmp = 64'd5;
        step("r_mip",   3'd2, 12'h344, 32'h0,   0, 0, 0, 3'd2, 32'h80,  32'h200);
        step("w_mie",   3'd1, 12'h304, 32'h80,  0, 0, 0, 3'd1, 32'h0,   32'h200);
        step("nordy",   3'd0, 12'h000, 32'h0,   0, 0, 0, 3'd0, 32'h0,   32'h200);
        chk_stall("stall_pend", 1'b1);
        step("irq",     3'd0, 12'h000, 32'h0,   0, 1, 32'h44, 3'd4, 32'h0, 32'h200);
        step("r_mepc2", 3'd2, 12'h341, 32'h0,   0, 0, 0, 3'd2, 32'h44,  32'h200);
        chk_stall("stall_after", 1'b0);
        step("r_mcause2",3'd2,12'h342, 32'h0,   0, 0, 0, 3'd2, 32'h8000_0007, 32'h200);
        step("s_mie2",  3'd2, 12'h300, 32'h8,   0, 0, 0, 3'd2, 32'h80,  32'h200);
        step("prio",    3'd1, 12'h340, 32'h55,  0, 1, 32'h60, 3'd1, 32'h0, 32'h200);
        chk_stall("stall_prio", 1'b1);
        step("hazard",  3'd1, 12'h340, 32'hFF,  1, 1, 32'h64, 3'd0, 32'h0, 32'h200);
        chk_stall("stall_hz", 1'b0);
        step("r_mscr",  3'd2, 12'h340, 32'h0,   0, 0, 0, 3'd2, 32'h55,  32'h200);
        step("r_mepc3", 3'd2, 12'h341, 32'h0,   0, 0, 0, 3'd2, 32'h44,  32'h200);
        step("c_mie",   3'd3, 12'h300, 32'h8,   0, 0, 0, 3'd3, 32'h88,  32'h200);
        // read-only counters
        reg_cycle = 64'h1_0000_0002;
        reg_time  = 64'h5_0000_0009;
        step("cycleh",  3'd2, 12'hC80, 32'h0,   0, 0, 0, 3'd2, 32'h1,   32'h200);
        step("cycle",   3'd2, 12'hC00, 32'h0,   0, 0, 0, 3'd2, 32'h2,   32'h200);
        step("time",    3'd2, 12'hC01, 32'h0,   0, 0, 0, 3'd2, 32'h9,   32'h200);
        step("timeh",   3'd2, 12'hC81, 32'h0,   0, 0, 0, 3'd2, 32'h5,   32'h200);
        step("fmax",    3'd2, 12'hFC0, 32'h0,   0, 0, 0, 3'd2, 32'd27,  32'h200);
        step("w_cycle", 3'd1, 12'hC00, 32'hFFFF,0, 0, 0, 3'd1, 32'h2,   32'h200);
        step("r_cycle2",3'd2, 12'hC00, 32'h0,   0, 0, 0, 3'd2, 32'h2,   32'h200);
        step("w_mscr",  3'd1, 12'h340, 32'h77,  0, 0, 0, 3'd1, 32'h55,  32'h200);
        // asynchronous reset in the middle of a cycle
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mrst.cmd", {29'b0, bus.output_csr_cmd}, 32'd0);
        check("mrst.rdata", bus.csr_rdata, 32'd0);
        check("mrst.tvec", bus.trap_vector, 32'd0);
        check("mrst.stall", {31'b0, stall}, 32'd0);
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        step("z_mscr",  3'd2, 12'h340, 32'h0,   0, 0, 0, 3'd2, 32'h0,   32'h0);
        step("z_mtvec", 3'd2, 12'h305, 32'h0,   0, 0, 0, 3'd2, 32'h0,   32'h0);
        step("z_mstat", 3'd2, 12'h300, 32'h0,   0, 0, 0, 3'd2, 32'h0,   32'h0);
        step("z_mie",   3'd2, 12'h304, 32'h0,   0, 1, 0, 3'd2, 32'h0,   32'h0);
        step("z_mepc",  3'd2, 12'h341, 32'h0,   0, 0, 0, 3'd2, 32'h0,   32'h0);
        step("z_mcause",3'd2, 12'h342, 32'h0,   0, 0, 0, 3'd2, 32'h0,   32'h0);
        chk_stall("z_stall", 1'b0);
        @(negedge clk) idle_inputs();
        @(posedge clk);
        #2;
        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
